// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg
//   Shared definitions for the decode stage: opcode constants, the canonical
//   decoded-instruction record and the 16-bit sign-extension helper.
//   decoded_t is sized for the widest supported datapath (XLEN_MAX/RBITS_MAX);
//   narrower instances zero-extend into it and slice back out.
package decode_queue_pkg;

    localparam int XLEN_MAX  = 64;
    localparam int RBITS_MAX = 8;

    localparam logic [5:0] OPCODE_ALUR = 6'h00;
    localparam logic [5:0] OPCODE_BEQ  = 6'h08;
    localparam logic [5:0] OPCODE_BLT  = 6'h09;
    localparam logic [5:0] OPCODE_BLE  = 6'h0A;
    localparam logic [5:0] OPCODE_BNE  = 6'h0B;
    localparam logic [5:0] OPCODE_JAL  = 6'h0C;
    localparam logic [5:0] OPCODE_LW   = 6'h12;
    localparam logic [5:0] OPCODE_SW   = 6'h1A;

    typedef struct packed {
        logic [XLEN_MAX-1:0]  pc;
        logic [5:0]           op;
        logic [7:0]           altop;
        logic [RBITS_MAX-1:0] rd;
        logic [RBITS_MAX-1:0] rs;
        logic [RBITS_MAX-1:0] rt;
        logic [XLEN_MAX-1:0]  imm;
        logic                 wr_en;
        logic                 is_branch;
        logic                 is_mem;
    } decoded_t;

    function automatic logic [XLEN_MAX-1:0] sext16(input logic [15:0] v);
        return {{(XLEN_MAX-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if
//   Fetch -> decode -> register-read handshake bundle.
//   Handshake rule: a beat transfers on a clock edge where its valid and the
//   matching ready are both 1 (fetch_valid/decode_ready for the fetch side,
//   decode_valid/rr_ready for the register-read side). decode_ready depends
//   only on registered occupancy, never on rr_ready. rr_flush discards all
//   queued work plus the same-cycle fetch beat; decode_flush mirrors it.
//   master: environment (fetch + register-read). slave: decode_queue.
interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int RBITS = 4,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             fetch_valid;
    logic [XLEN-1:0]  fetch_pc;
    logic [31:0]      fetch_inst;
    logic             decode_ready;
    logic             rr_ready;
    logic             rr_flush;
    logic             decode_flush;
    logic             decode_valid;
    logic [XLEN-1:0]  decode_pc;
    logic [5:0]       decode_op;
    logic [7:0]       decode_altop;
    logic [RBITS-1:0] decode_rd;
    logic [RBITS-1:0] decode_rs;
    logic [RBITS-1:0] decode_rt;
    logic [XLEN-1:0]  decode_imm;
    logic             decode_wr_en;
    logic             decode_is_branch;
    logic             decode_is_mem;
    logic [CW-1:0]    decode_count;

    modport master (
        output fetch_valid, fetch_pc, fetch_inst, rr_ready, rr_flush,
        input  decode_ready, decode_flush, decode_valid, decode_pc, decode_op,
               decode_altop, decode_rd, decode_rs, decode_rt, decode_imm,
               decode_wr_en, decode_is_branch, decode_is_mem, decode_count
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_inst, rr_ready, rr_flush,
        output decode_ready, decode_flush, decode_valid, decode_pc, decode_op,
               decode_altop, decode_rd, decode_rs, decode_rt, decode_imm,
               decode_wr_en, decode_is_branch, decode_is_mem, decode_count
    );

endinterface

// File: rtl/decode_queue_fields.sv
// decode_fields
//   Purely combinational instruction decoder.
//   Ports: pc   - PC of the instruction (XLEN bits)
//          inst - raw 32-bit instruction
//          dec  - canonical decoded record (decoded_t, zero-extended to max widths)
module decode_fields
    import decode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     inst,
    output decoded_t        dec
);

    logic [5:0]      op;
    logic [7:0]      altop_f;
    logic [15:0]     imm16;
    logic [3:0]      rd_f;
    logic [3:0]      rs_f;
    logic [3:0]      rt_f;
    logic [XLEN-1:0] simm;

    // Fields overlap on purpose: imm16 shares bits with altop and rd.
    assign op      = inst[31:26];
    assign altop_f = inst[25:18];
    assign imm16   = inst[23:8];
    assign rd_f    = inst[11:8];
    assign rs_f    = inst[7:4];
    assign rt_f    = inst[3:0];
    assign simm    = XLEN'(sext16(imm16));

    always_comb begin
        dec       = '0;
        dec.pc    = XLEN_MAX'(pc);
        dec.op    = op;
        dec.altop = altop_f;
        dec.rs    = RBITS_MAX'(rs_f);
        case (op)
            OPCODE_ALUR: begin
                dec.rd = RBITS_MAX'(rd_f);
                dec.rt = RBITS_MAX'(rt_f);
            end
            OPCODE_BEQ, OPCODE_BLT, OPCODE_BLE, OPCODE_BNE: begin
                dec.rt        = RBITS_MAX'(rt_f);
                // Target wraps modulo 2^XLEN before widening.
                dec.imm       = XLEN_MAX'(pc + XLEN'(4) + (simm << 2));
                dec.is_branch = 1'b1;
            end
            OPCODE_JAL: begin
                dec.rd        = RBITS_MAX'(rt_f);
                dec.imm       = XLEN_MAX'(simm << 2);
                dec.is_branch = 1'b1;
            end
            OPCODE_LW: begin
                dec.rd     = RBITS_MAX'(rt_f);
                dec.imm    = XLEN_MAX'(simm);
                dec.is_mem = 1'b1;
            end
            OPCODE_SW: begin
                dec.rt     = RBITS_MAX'(rt_f);
                dec.imm    = XLEN_MAX'(simm);
                dec.is_mem = 1'b1;
            end
            default: begin
                // ALU-immediate: the opcode itself selects the operation.
                dec.rt    = RBITS_MAX'(rt_f);
                dec.imm   = XLEN_MAX'(simm);
                dec.altop = {2'b00, op};
            end
        endcase
        dec.wr_en = (dec.rd != '0);
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue
//   Decode stage with a DEPTH-entry FIFO between fetch and register-read.
//   Ports: i_clk   - clock
//          i_reset - asynchronous active-high reset
//          bus     - decode_queue_if.slave (fetch beat in, decoded head out,
//                    occupancy in decode_count)
//   An accepted beat is visible at the head no earlier than the next cycle.
//   While empty, every head field reads 0.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RBITS = 4,
    parameter int DEPTH = 2
) (
    input logic           i_clk,
    input logic           i_reset,
    decode_queue_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    decoded_t      mem [DEPTH];
    decoded_t      dec;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          enq;
    logic          deq;

    decode_fields #(.XLEN(XLEN)) u_fields (
        .pc   (bus.fetch_pc),
        .inst (bus.fetch_inst),
        .dec  (dec)
    );

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty            = (count == '0);
    assign bus.decode_ready = (count < CW'(DEPTH));
    assign bus.decode_flush = bus.rr_flush;
    assign bus.decode_count = count;
    // Flush wins over both sides of the handshake.
    assign enq = bus.fetch_valid & bus.decode_ready & ~bus.rr_flush;
    assign deq = ~empty & bus.rr_ready & ~bus.rr_flush;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.rr_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= bump(wr_ptr);
            if (deq) rd_ptr <= bump(rd_ptr);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (enq) mem[wr_ptr] <= dec;
    end

    always_comb begin
        bus.decode_valid     = ~empty;
        bus.decode_pc        = '0;
        bus.decode_op        = '0;
        bus.decode_altop     = '0;
        bus.decode_rd        = '0;
        bus.decode_rs        = '0;
        bus.decode_rt        = '0;
        bus.decode_imm       = '0;
        bus.decode_wr_en     = 1'b0;
        bus.decode_is_branch = 1'b0;
        bus.decode_is_mem    = 1'b0;
        if (!empty) begin
            bus.decode_pc        = mem[rd_ptr].pc[XLEN-1:0];
            bus.decode_op        = mem[rd_ptr].op;
            bus.decode_altop     = mem[rd_ptr].altop;
            bus.decode_rd        = mem[rd_ptr].rd[RBITS-1:0];
            bus.decode_rs        = mem[rd_ptr].rs[RBITS-1:0];
            bus.decode_rt        = mem[rd_ptr].rt[RBITS-1:0];
            bus.decode_imm       = mem[rd_ptr].imm[XLEN-1:0];
            bus.decode_wr_en     = mem[rd_ptr].wr_en;
            bus.decode_is_branch = mem[rd_ptr].is_branch;
            bus.decode_is_mem    = mem[rd_ptr].is_mem;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue
//   Two instances share the same stimulus: XLEN=32/RBITS=4/DEPTH=2 and
//   XLEN=64/RBITS=5/DEPTH=3. A queue model per instance predicts the head
//   and occupancy; directed literal checks pin the model's arithmetic.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int D32 = 2;
    localparam int D64 = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(32), .RBITS(4), .DEPTH(D32)) if32 ();
    decode_queue_if #(.XLEN(64), .RBITS(5), .DEPTH(D64)) if64 ();

    decode_queue #(.XLEN(32), .RBITS(4), .DEPTH(D32)) u_dut32 (
        .i_clk (clk), .i_reset (rst), .bus (if32)
    );
    decode_queue #(.XLEN(64), .RBITS(5), .DEPTH(D64)) u_dut64 (
        .i_clk (clk), .i_reset (rst), .bus (if64)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [5:0]  op;
        logic [7:0]  altop;
        logic [7:0]  rd;
        logic [7:0]  rs;
        logic [7:0]  rt;
        logic [63:0] imm;
        logic        wr_en;
        logic        is_branch;
        logic        is_mem;
    } exp_t;

    exp_t exp_q32[$];
    exp_t exp_q64[$];
    int   checks   = 0;
    int   failures = 0;

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [63:0] pc, input logic [31:0] inst, input int xlen);
        exp_t        e;
        logic [63:0] mask;
        longint      off;
        mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        off   = longint'($signed(inst[23:8]));
        e     = '0;
        e.pc  = pc & mask;
        e.op  = inst[31:26];
        e.altop = inst[25:18];
        e.rs  = 8'(inst[7:4]);
        if (inst[31:26] == OPCODE_ALUR) begin
            e.rd = 8'(inst[11:8]);
            e.rt = 8'(inst[3:0]);
        end else if (inst[31:26] == OPCODE_BEQ || inst[31:26] == OPCODE_BLT ||
                     inst[31:26] == OPCODE_BLE || inst[31:26] == OPCODE_BNE) begin
            e.rt  = 8'(inst[3:0]);
            e.imm = (pc + 64'd4 + 64'(off * 4)) & mask;
            e.is_branch = 1'b1;
        end else if (inst[31:26] == OPCODE_JAL) begin
            e.rd  = 8'(inst[3:0]);
            e.imm = 64'(off * 4) & mask;
            e.is_branch = 1'b1;
        end else if (inst[31:26] == OPCODE_LW) begin
            e.rd  = 8'(inst[3:0]);
            e.imm = 64'(off) & mask;
            e.is_mem = 1'b1;
        end else if (inst[31:26] == OPCODE_SW) begin
            e.rt  = 8'(inst[3:0]);
            e.imm = 64'(off) & mask;
            e.is_mem = 1'b1;
        end else begin
            e.rt    = 8'(inst[3:0]);
            e.imm   = 64'(off) & mask;
            e.altop = {2'b00, inst[31:26]};
        end
        e.wr_en = (e.rd != 8'd0);
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit enq32, deq32, enq64, deq64;
        if (rst || if32.rr_flush) begin
            exp_q32.delete();
            exp_q64.delete();
        end else begin
            enq32 = if32.fetch_valid && (exp_q32.size() < D32);
            deq32 = (exp_q32.size() > 0) && if32.rr_ready;
            enq64 = if64.fetch_valid && (exp_q64.size() < D64);
            deq64 = (exp_q64.size() > 0) && if64.rr_ready;
            if (deq32) void'(exp_q32.pop_front());
            if (enq32) exp_q32.push_back(model(64'(if32.fetch_pc), if32.fetch_inst, 32));
            if (deq64) void'(exp_q64.pop_front());
            if (enq64) exp_q64.push_back(model(if64.fetch_pc, if64.fetch_inst, 64));
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ent(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t a32, a64, e32, e64;
        a32 = '0;
        a32.pc = 64'(if32.decode_pc);   a32.op = if32.decode_op;  a32.altop = if32.decode_altop;
        a32.rd = 8'(if32.decode_rd);    a32.rs = 8'(if32.decode_rs); a32.rt = 8'(if32.decode_rt);
        a32.imm = 64'(if32.decode_imm); a32.wr_en = if32.decode_wr_en;
        a32.is_branch = if32.decode_is_branch; a32.is_mem = if32.decode_is_mem;
        a64 = '0;
        a64.pc = if64.decode_pc;        a64.op = if64.decode_op;  a64.altop = if64.decode_altop;
        a64.rd = 8'(if64.decode_rd);    a64.rs = 8'(if64.decode_rs); a64.rt = 8'(if64.decode_rt);
        a64.imm = if64.decode_imm;      a64.wr_en = if64.decode_wr_en;
        a64.is_branch = if64.decode_is_branch; a64.is_mem = if64.decode_is_mem;
        e32 = (exp_q32.size() > 0) ? exp_q32[0] : '0;
        e64 = (exp_q64.size() > 0) ? exp_q64[0] : '0;
        chk("m32_valid", 64'(if32.decode_valid), 64'(exp_q32.size() > 0));
        chk("m32_count", 64'(if32.decode_count), 64'(exp_q32.size()));
        chk("m32_ready", 64'(if32.decode_ready), 64'(exp_q32.size() < D32));
        chk("m32_flush", 64'(if32.decode_flush), 64'(if32.rr_flush));
        chk_ent("m32_head", a32, e32);
        chk("m64_valid", 64'(if64.decode_valid), 64'(exp_q64.size() > 0));
        chk("m64_count", 64'(if64.decode_count), 64'(exp_q64.size()));
        chk("m64_ready", 64'(if64.decode_ready), 64'(exp_q64.size() < D64));
        chk_ent("m64_head", a64, e64);
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] ins(input logic [5:0] op, input logic [1:0] hi,
                                        input logic [15:0] imm16, input logic [7:0] lo);
        return {op, hi, imm16, lo};
    endfunction

    task automatic set_in(input logic fv, input logic [31:0] inst, input logic [63:0] pc,
                          input logic rr, input logic fl);
        if32.fetch_valid = fv;  if64.fetch_valid = fv;
        if32.fetch_inst  = inst; if64.fetch_inst = inst;
        if32.fetch_pc    = pc[31:0]; if64.fetch_pc = pc;
        if32.rr_ready    = rr;  if64.rr_ready = rr;
        if32.rr_flush    = fl;  if64.rr_flush = fl;
    endtask

    task automatic cyc(input logic fv, input logic [31:0] inst, input logic [63:0] pc,
                       input logic rr, input logic fl);
        set_in(fv, inst, pc, rr, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] tbl [9];

    initial begin
        logic [63:0] pc;
        set_in(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        tbl[0] = ins(OPCODE_ALUR, 2'b00, 16'h0003, 8'h12);
        tbl[1] = ins(OPCODE_BEQ,  2'b00, 16'h0003, 8'h12);
        tbl[2] = ins(OPCODE_BNE,  2'b01, 16'hFFFF, 8'h45);
        tbl[3] = ins(OPCODE_LW,   2'b00, 16'h8000, 8'h25);
        tbl[4] = ins(OPCODE_SW,   2'b00, 16'h8000, 8'h25);
        tbl[5] = ins(OPCODE_JAL,  2'b00, 16'hFFFE, 8'h37);
        tbl[6] = ins(6'h21,       2'b11, 16'h1234, 8'h56);
        tbl[7] = ins(OPCODE_BLT,  2'b00, 16'hFFF0, 8'h9A);
        tbl[8] = ins(OPCODE_ALUR, 2'b10, 16'hA0F0, 8'h9C);

        // Reset state.
        repeat (2) @(posedge clk);
        look();
        chk("rst_valid", 64'(if32.decode_valid), 64'd0);
        chk("rst_count", 64'(if32.decode_count), 64'd0);
        chk("rst_ready", 64'(if32.decode_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU R-type.
        cyc(1'b1, tbl[0], 64'h100, 1'b1, 1'b0);
        look();
        chk("r_valid", 64'(if32.decode_valid), 64'd1);
        chk("r_rd", 64'(if32.decode_rd), 64'd3);
        chk("r_rs", 64'(if32.decode_rs), 64'd1);
        chk("r_rt", 64'(if32.decode_rt), 64'd2);
        chk("r_imm", 64'(if32.decode_imm), 64'd0);
        chk("r_wr_en", 64'(if32.decode_wr_en), 64'd1);

        // Branch targets, forward and backward.
        cyc(1'b1, tbl[1], 64'h100, 1'b1, 1'b0);
        look();
        chk("beq_imm", 64'(if32.decode_imm), 64'h110);
        chk("beq_rd", 64'(if32.decode_rd), 64'd0);
        chk("beq_br", 64'(if32.decode_is_branch), 64'd1);
        cyc(1'b1, ins(OPCODE_BEQ, 2'b00, 16'hFFFF, 8'h12), 64'h100, 1'b1, 1'b0);
        look();
        chk("beq_neg_imm", 64'(if32.decode_imm), 64'h100);
        chk("beq_neg_imm64", if64.decode_imm, 64'h100);
        cyc(1'b1, tbl[7], 64'h4, 1'b1, 1'b0);
        look();
        chk("blt_wrap32", 64'(if32.decode_imm), 64'hFFFF_FFC8);
        chk("blt_wrap64", if64.decode_imm, 64'hFFFF_FFFF_FFFF_FFC8);

        // Loads and stores.
        cyc(1'b1, tbl[3], 64'h108, 1'b1, 1'b0);
        look();
        chk("lw_rd", 64'(if32.decode_rd), 64'd5);
        chk("lw_rs", 64'(if32.decode_rs), 64'd2);
        chk("lw_rt", 64'(if32.decode_rt), 64'd0);
        chk("lw_imm", 64'(if32.decode_imm), 64'hFFFF_8000);
        chk("lw_imm64", if64.decode_imm, 64'hFFFF_FFFF_FFFF_8000);
        chk("lw_mem", 64'(if32.decode_is_mem), 64'd1);
        cyc(1'b1, tbl[4], 64'h10C, 1'b1, 1'b0);
        look();
        chk("sw_rd", 64'(if32.decode_rd), 64'd0);
        chk("sw_rt", 64'(if32.decode_rt), 64'd5);
        chk("sw_wr_en", 64'(if32.decode_wr_en), 64'd0);

        cyc(1'b1, tbl[5], 64'h110, 1'b1, 1'b0);
        cyc(1'b1, tbl[6], 64'h114, 1'b1, 1'b0);
        look();
        chk("alui_altop", 64'(if32.decode_altop), 64'h21);
        cyc(1'b1, tbl[8], 64'h118, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        look();
        chk("empty_valid", 64'(if32.decode_valid), 64'd0);
        chk("empty_pc", 64'(if32.decode_pc), 64'd0);

        // Backpressure: fill, hold the third beat, release one slot.
        cyc(1'b1, tbl[0], 64'h200, 1'b0, 1'b0);
        cyc(1'b1, tbl[1], 64'h204, 1'b0, 1'b0);
        look();
        chk("full_count", 64'(if32.decode_count), 64'd2);
        chk("full_ready", 64'(if32.decode_ready), 64'd0);
        cyc(1'b1, tbl[3], 64'h208, 1'b0, 1'b0);
        look();
        chk("held_count", 64'(if32.decode_count), 64'd2);
        chk("held_head", 64'(if32.decode_pc), 64'h200);
        cyc(1'b1, tbl[3], 64'h208, 1'b1, 1'b0);
        look();
        chk("drain1_count", 64'(if32.decode_count), 64'd1);
        chk("drain1_ready", 64'(if32.decode_ready), 64'd1);
        chk("drain1_head", 64'(if32.decode_pc), 64'h204);
        cyc(1'b1, tbl[3], 64'h208, 1'b0, 1'b0);

        // Flush while full; the flush-cycle beat must be dropped.
        set_in(1'b1, tbl[6], 64'h20C, 1'b1, 1'b1);
        #1;
        chk("flush_mirror", 64'(if32.decode_flush), 64'd1);
        @(posedge clk); #1;
        set_in(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        look();
        chk("flush_count", 64'(if32.decode_count), 64'd0);
        chk("flush_valid", 64'(if32.decode_valid), 64'd0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        cyc(1'b1, tbl[0], 64'h300, 1'b0, 1'b0);
        cyc(1'b1, tbl[1], 64'h304, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_valid32", 64'(if32.decode_valid), 64'd0);
        chk("areset_count32", 64'(if32.decode_count), 64'd0);
        chk("areset_valid64", 64'(if64.decode_valid), 64'd0);
        chk("areset_count64", 64'(if64.decode_count), 64'd0);
        set_in(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b1, tbl[3], 64'h400, 1'b1, 1'b0);
        look();
        chk("post_rst_pc", 64'(if32.decode_pc), 64'h400);
        chk("post_rst_rd", 64'(if32.decode_rd), 64'd5);
        chk("post_rst_imm", 64'(if32.decode_imm), 64'hFFFF_8000);

        // Mixed traffic over the directed table, checked by the model.
        pc = 64'h1000;
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 1)), tbl[$urandom_range(0, 8)], pc,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
            pc = pc + 64'd4;
        end
        repeat (4) cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        look();
        chk("final_count", 64'(if32.decode_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
